// File: rtl/sync_debouncer.sv
// Multi-channel input conditioner: STAGES-deep synchronizer, tick-sampled
// saturating debounce counter per channel, registered level and edge pulses.
module sync_debouncer #(
    parameter int WIDTH          = 1,
    parameter int STAGES         = 2,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_signal,
    output logic [WIDTH-1:0] sync_signal,
    output logic [WIDTH-1:0] debounced_signal,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    // A one-cycle sample period still needs a 1-bit counter register.
    localparam int TW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int CW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_SAT   = CW'(PULSE_CNT_MAX);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [TW-1:0]    tick_cnt;
    logic             tick;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= async_signal;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_signal = sync_q[STAGES-1];

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // A low synchronized sample always restarts the count, tick or not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!sync_signal[i]) begin
                    cnt[i] <= '0;
                end else if (tick && (cnt[i] < CNT_SAT)) begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            debounced_signal <= '0;
            prev_q           <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                debounced_signal[i] <= (cnt[i] == CNT_SAT);
            end
            prev_q <= debounced_signal;
        end
    end

    // Pulses decode registers only, so they cannot glitch.
    assign rise_pulse = debounced_signal & ~prev_q;
    assign fall_pulse = ~debounced_signal & prev_q;

endmodule

// File: tb/tb_sync_debouncer.sv
// Self-checking bench for sync_debouncer: directed scenarios plus random
// stimulus, all compared against a delay-line / tick-count reference model.
module tb_sync_debouncer;

    localparam int W = 2;
    localparam int STAGES = 2;
    localparam int S = 4;
    localparam int P = 3;

    logic         clk;
    logic         rst;
    logic [W-1:0] async_signal;
    logic [W-1:0] sync_signal;
    logic [W-1:0] debounced_signal;
    logic [W-1:0] rise_pulse;
    logic [W-1:0] fall_pulse;

    int tests = 0;
    int fails = 0;

    sync_debouncer #(
        .WIDTH(W), .STAGES(STAGES), .SAMPLE_CNT_MAX(S), .PULSE_CNT_MAX(P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .async_signal(async_signal),
        .sync_signal(sync_signal),
        .debounced_signal(debounced_signal),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: sync is the input seen STAGES edges ago; a channel is
    // stable once it has witnessed P ticks while continuously high.
    int           m_cyc;
    int           m_run [W];
    logic [W-1:0] m_sync, m_deb, m_prev;
    logic [W-1:0] m_hist [$];
    bit           m_tick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0;
            m_hist.delete();
            m_sync = '0;
            m_deb = '0;
            m_prev = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_tick = ((m_cyc % S) == S - 1);
            m_prev = m_deb;
            for (int i = 0; i < W; i++) m_deb[i] = (m_run[i] >= P);
            for (int i = 0; i < W; i++) m_run[i] = m_sync[i] ? m_run[i] + (m_tick ? 1 : 0) : 0;
            m_hist.push_back(async_signal);
            if (m_hist.size() > STAGES) void'(m_hist.pop_front());
            m_sync = (m_hist.size() == STAGES) ? m_hist[0] : '0;
            m_cyc++;
        end
    end

    function automatic logic [4*W-1:0] exp_vec();
        return {m_sync, m_deb, m_deb & ~m_prev, ~m_deb & m_prev};
    endfunction

    function automatic logic [4*W-1:0] dut_vec();
        return {sync_signal, debounced_signal, rise_pulse, fall_pulse};
    endfunction

    task automatic test_reset();
        int lat;
        int rises [W];
        int falls;
        lat = 0;
        falls = 0;
        for (int i = 0; i < W; i++) rises[i] = 0;
        rst = 1'b1;
        async_signal = 2'b11;
        repeat (3) @(negedge clk);
        tests++;
        if (dut_vec() !== '0) begin
            fails++;
            $display("FAIL reset_hold: got %b exp %b", dut_vec(), {4*W{1'b0}});
        end
        rst = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL reset_model c%0d: got %b exp %b", n, dut_vec(), exp_vec());
            end
            if (n == 1 || n == 2) begin
                tests++;
                if (sync_signal !== ((n == 2) ? 2'b11 : 2'b00)) begin
                    fails++;
                    $display("FAIL reset_sync_lat c%0d: got %b exp %b", n, sync_signal,
                             (n == 2) ? 2'b11 : 2'b00);
                end
            end
            if (lat == 0 && debounced_signal === 2'b11) lat = n;
            for (int i = 0; i < W; i++) rises[i] += (rise_pulse[i] === 1'b1) ? 1 : 0;
            if (fall_pulse !== 2'b00) falls++;
        end
        tests++;
        if (lat < 11 || lat > 15) begin
            fails++;
            $display("FAIL reset_deb_latency: got %0d exp 11..15", lat);
        end
        tests++;
        if (rises[0] != 1 || rises[1] != 1) begin
            fails++;
            $display("FAIL reset_rise_count: got %0d/%0d exp 1/1", rises[1], rises[0]);
        end
        tests++;
        if (falls != 0) begin
            fails++;
            $display("FAIL reset_no_fall: got %0d exp 0", falls);
        end
    endtask

    task automatic test_release();
        int fall_n;
        int falls;
        fall_n = 0;
        falls = 0;
        async_signal[0] = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL release_model c%0d: got %b exp %b", n, dut_vec(), exp_vec());
            end
            if (fall_pulse[0] === 1'b1) begin
                falls++;
                fall_n = n;
                tests++;
                if (debounced_signal[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL release_deb_low: got %b exp 0", debounced_signal[0]);
                end
            end
        end
        tests++;
        if (falls != 1 || fall_n != 4) begin
            fails++;
            $display("FAIL release_fall: got count %0d at %0d exp count 1 at 4", falls, fall_n);
        end
    endtask

    task automatic test_glitch();
        int sync_hi;
        int bad;
        sync_hi = 0;
        bad = 0;
        repeat (4) @(negedge clk);
        async_signal[0] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            if (n == 7) async_signal[0] = 1'b0;
            @(negedge clk);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL glitch_model c%0d: got %b exp %b", n, dut_vec(), exp_vec());
            end
            if (sync_signal[0] === 1'b1) sync_hi++;
            if (debounced_signal[0] !== 1'b0 || rise_pulse[0] !== 1'b0 || fall_pulse[0] !== 1'b0) bad++;
        end
        tests++;
        if (sync_hi != 6) begin
            fails++;
            $display("FAIL glitch_sync_width: got %0d exp 6", sync_hi);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL glitch_rejected: got %0d active cycles exp 0", bad);
        end
    endtask

    task automatic test_independence();
        int b0_bad;
        int b1_bad;
        int r1;
        int r0;
        b0_bad = 0;
        b1_bad = 0;
        r1 = 0;
        r0 = 0;
        async_signal = 2'b00;
        repeat (6) @(negedge clk);
        async_signal[1] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL indep1_model c%0d: got %b exp %b", n, dut_vec(), exp_vec());
            end
            if ({sync_signal[0], debounced_signal[0], rise_pulse[0], fall_pulse[0]} !== 4'b0) b0_bad++;
            if (rise_pulse[1] === 1'b1) r1++;
        end
        async_signal[0] = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL indep0_model c%0d: got %b exp %b", n, dut_vec(), exp_vec());
            end
            if ({debounced_signal[1], rise_pulse[1], fall_pulse[1]} !== 3'b100) b1_bad++;
            if (rise_pulse[0] === 1'b1) r0++;
        end
        tests++;
        if (b0_bad != 0 || r1 != 1) begin
            fails++;
            $display("FAIL indep_bit1_only: got b0 active %0d rise1 %0d exp 0 and 1", b0_bad, r1);
        end
        tests++;
        if (b1_bad != 0 || r0 != 1) begin
            fails++;
            $display("FAIL indep_bit0_add: got b1 disturbed %0d rise0 %0d exp 0 and 1", b1_bad, r0);
        end
    endtask

    task automatic test_saturation();
        int r0;
        int f0;
        r0 = 0;
        f0 = 0;
        async_signal[0] = 1'b0;
        repeat (8) @(negedge clk);
        async_signal[0] = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL sat_model c%0d: got %b exp %b", n, dut_vec(), exp_vec());
            end
            if (rise_pulse[0] === 1'b1) r0++;
            if (fall_pulse[0] === 1'b1) f0++;
        end
        tests++;
        if (r0 != 1 || f0 != 0 || debounced_signal[0] !== 1'b1) begin
            fails++;
            $display("FAIL sat_hold: got rise %0d fall %0d deb %b exp 1 0 1", r0, f0, debounced_signal[0]);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        int rises;
        int falls;
        lat = 0;
        rises = 0;
        falls = 0;
        @(negedge clk);
        tests++;
        if (debounced_signal !== 2'b11) begin
            fails++;
            $display("FAIL midrst_pre: got %b exp 11", debounced_signal);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (dut_vec() !== '0) begin
            fails++;
            $display("FAIL midrst_immediate: got %b exp %b", dut_vec(), {4*W{1'b0}});
        end
        repeat (2) @(negedge clk);
        tests++;
        if (dut_vec() !== '0) begin
            fails++;
            $display("FAIL midrst_hold: got %b exp %b", dut_vec(), {4*W{1'b0}});
        end
        rst = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL midrst_model c%0d: got %b exp %b", n, dut_vec(), exp_vec());
            end
            if (lat == 0 && debounced_signal === 2'b11) lat = n;
            if (rise_pulse === 2'b11) rises++;
            if (fall_pulse !== 2'b00) falls++;
        end
        tests++;
        if (lat < 11 || lat > 15 || rises != 1 || falls != 0) begin
            fails++;
            $display("FAIL midrst_recover: got lat %0d rise %0d fall %0d exp 11..15 1 0", lat, rises, falls);
        end
    endtask

    task automatic test_random();
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random_model c%0d: got %b exp %b", n, dut_vec(), exp_vec());
            end
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 15) == 0) async_signal[i] = ~async_signal[i];
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        async_signal = '0;
        @(negedge clk);
        test_reset();
        test_release();
        test_glitch();
        test_independence();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_debouncer.md
Name: sync_debouncer

Overview:
Parametrised successor to the 2-flop synchronizer. It brings WIDTH asynchronous inputs (buttons, switches, foreign-domain levels) into the clk domain through a STAGES-deep flop chain per channel. It then debounces each channel with a saturating counter driven by a shared sample tick, and emits registered stable levels plus one-cycle rising/falling edge pulses. It sits between board IO pins and user logic (FSMs, UART/button control).

Parameters:
WIDTH, 1, number of independent channels
STAGES, 2, synchronizer flops per channel; legal range >= 2
SAMPLE_CNT_MAX, 25000, period of the shared sample tick in clk cycles; legal range >= 1
PULSE_CNT_MAX, 150, consecutive high samples required to declare a channel stable; legal range >= 1

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
async_signal  input  WIDTH  raw asynchronous inputs
sync_signal  output  WIDTH  raw synchronized level (last flop of chain), no debounce
debounced_signal  output  WIDTH  registered debounced level
rise_pulse  output  WIDTH  one-cycle pulse when debounced_signal goes 0->1
fall_pulse  output  WIDTH  one-cycle pulse when debounced_signal goes 1->0

Behaviour:
- Reset (async, rst=1): every sync flop, the tick counter, all channel counters, debounced_signal and the prev-level register are cleared to 0. All outputs read 0 while rst=1 and in the first cycle after release.
- Synchronizer: per bit, a STAGES-deep shift register. sync_signal is the last stage. Latency from a stable async change to sync_signal is STAGES posedges. No logic between stages.
- Tick counter: width $clog2(SAMPLE_CNT_MAX). Counts 0..SAMPLE_CNT_MAX-1 and wraps to 0. tick=1 for exactly one cycle when the count equals SAMPLE_CNT_MAX-1. With SAMPLE_CNT_MAX=1, tick is 1 every cycle. The tick counter is shared by all channels and free-runs from reset.
- Channel counter cnt[i]: width $clog2(PULSE_CNT_MAX+1). Priority order:
  - If sync_signal[i]=0: cnt <= 0 on every cycle, with or without a tick.
  - Else if tick and cnt < PULSE_CNT_MAX: cnt <= cnt+1.
  - Else: hold. cnt saturates at PULSE_CNT_MAX and never wraps.
- debounced_signal[i] <= (cnt[i] == PULSE_CNT_MAX). It is registered one cycle after the count saturates. It deasserts one cycle after cnt clears, and cnt clears in the cycle after sync_signal falls. Release is therefore effectively immediate; only assertion is filtered.
- Edge pulses: prev[i] <= debounced_signal[i].
  - rise_pulse = debounced_signal & ~prev.
  - fall_pulse = ~debounced_signal & prev.
  - Both are functions of registers only (glitch-free), exactly one cycle wide, and never asserted together on the same bit.
- Glitch rejection: any low sample on sync_signal before saturation restarts the count from 0. A high glitch shorter than PULSE_CNT_MAX ticks produces no debounced change and no pulse.
- Channels are fully independent. Simultaneous events on several bits produce simultaneous per-bit pulses.
- Reset mid-operation: in-flight counts are discarded. No pulse is produced on entry to or exit from reset, including when debounced was 1 before reset.
- Assertion latency from a clean async rise to debounced_signal:
  - minimum STAGES + 1 + (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX + 1 cycles;
  - maximum STAGES + PULSE_CNT_MAX*SAMPLE_CNT_MAX + 1 cycles;
  - the exact value depends on tick phase.

Test Plan:
(All with WIDTH=2, STAGES=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3.)
1. Reset: hold rst=1 with async_signal=2'b11 -> all outputs 0. Release -> sync_signal=2'b11 after 2 posedges. debounced_signal[1:0]=2'b11 within 11..15 cycles of release. rise_pulse=2'b11 for exactly 1 cycle. fall_pulse stays 0.
2. Glitch: async_signal[0] high for 6 cycles, then low -> debounced_signal[0], rise_pulse[0] and fall_pulse[0] never assert. sync_signal[0] shows a 6-cycle pulse delayed by 2 cycles.
3. Release: with channel 0 stable high, drop async_signal[0] -> fall_pulse[0]=1 for exactly 1 cycle, 4 cycles after the drop (2 sync + cnt clear + debounced register). debounced_signal[0]=0 in that same cycle.
4. Independence: assert bit 1 only and hold -> only bit-1 outputs change. Then assert bit 0 while bit 1 is stable -> bit-1 outputs unchanged, bit-0 rise_pulse fires once.
5. Saturation: hold bit 0 high for 200 cycles -> debounced_signal[0] stays 1, rise_pulse[0] fires exactly once, and no wrap-induced fall_pulse occurs.
6. Mid-operation reset: assert rst asynchronously (between edges) while debounced=2'b11 -> outputs go 0 immediately with no fall_pulse. After release with inputs still high -> a fresh rise_pulse follows the full latency from scenario 1.
